// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with registered sync, window, coordinate and strobe outputs.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int CW       = 10
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic [CW-1:0] iLineCmp,
  output logic          oVGA_HS,
  output logic          oVGA_VS,
  output logic          oActive,
  output logic          oVBlank,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          oLineStart,
  output logic          oFrameStart,
  output logic          oLineIrq,
  output logic          oPixTick
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  if (H_TOTAL - 1 >= (1 << CW) || V_TOTAL - 1 >= (1 << CW)) begin : g_cw_err
    $error("vga_timing_gen: CW too small for H_TOTAL-1 or V_TOTAL-1");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_err
    $error("vga_timing_gen: CLK_DIV must be within 1..16");
  end
  localparam logic [3:0]    DM1 = 4'(CLK_DIV - 1);
  localparam logic [CW-1:0] HT1 = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VT1 = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HSE = CW'(H_SYNC);
  localparam logic [CW-1:0] VSE = CW'(V_SYNC);
  localparam logic [CW-1:0] HA0 = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] VA0 = CW'(V_SYNC + V_BP);
  // Inclusive last active index, so a zero front porch cannot overflow CW.
  localparam logic [CW-1:0] HAL = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CW-1:0] VAL = CW'(V_SYNC + V_BP + V_ACTIVE - 1);
  logic [3:0]    div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          tick, h_end, h_act, v_act, act;
  logic          hs_q, hs_d, vs_q, vs_d, act_q, vb_q;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          ls_q, ls_d, fs_q, fs_d, irq_q, irq_d, pt_q;
  always_comb begin
    tick  = div_q == DM1;
    h_end = h_q == HT1;
    div_d = tick ? 4'd0 : div_q + 4'd1;
    h_d   = !tick ? h_q : h_end ? '0 : h_q + CW'(1);
    v_d   = !(tick && h_end) ? v_q : (v_q == VT1) ? '0 : v_q + CW'(1);
    h_act = h_q >= HA0 && h_q <= HAL;
    v_act = v_q >= VA0 && v_q <= VAL;
    act   = h_act && v_act;
    hs_d  = (h_q < HSE) ? HS_POL : ~HS_POL;
    vs_d  = (v_q < VSE) ? VS_POL : ~VS_POL;
    x_d   = act ? h_q - HA0 : '0;
    y_d   = act ? v_q - VA0 : '0;
    ls_d  = tick && h_q == '0;
    fs_d  = ls_d && v_q == '0;
    irq_d = ls_d && v_q == iLineCmp;
  end
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      act_q <= 1'b0;
      vb_q  <= 1'b1;
      x_q   <= '0;
      y_q   <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      irq_q <= 1'b0;
      pt_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act;
      vb_q  <= ~v_act;
      x_q   <= x_d;
      y_q   <= y_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      irq_q <= irq_d;
      pt_q  <= tick;
    end
  end
  assign oVGA_HS     = hs_q;
  assign oVGA_VS     = vs_q;
  assign oActive     = act_q;
  assign oVBlank     = vb_q;
  assign oX          = x_q;
  assign oY          = y_q;
  assign oLineStart  = ls_q;
  assign oFrameStart = fs_q;
  assign oLineIrq    = irq_q;
  assign oPixTick    = pt_q;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator; next generation of the fixed 640x480 sync block.
- All horizontal and vertical timing, sync polarities and pixel-clock division are parameters.
- Adds registered outputs, frame/line start strobes, a blanking flag and a programmable line-compare interrupt.
- Sits between the system clock and the pixel pipeline (pong renderer, later sprite/text engines), which consume oX/oY/oActive.

Parameters:
H_SYNC, 96, horizontal sync width in pixels
H_BP, 48, horizontal back porch in pixels
H_ACTIVE, 640, horizontal visible pixels
H_FP, 16, horizontal front porch in pixels
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
V_ACTIVE, 480, vertical visible lines
V_FP, 10, vertical front porch in lines
HS_POL, 0, active level of oVGA_HS (0 = active-low)
VS_POL, 0, active level of oVGA_VS (0 = active-low)
CLK_DIV, 1, iclk cycles per pixel, 1..16
CW, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
iclk  input  1  system clock
irst  input  1  asynchronous reset, active-high
iLineCmp  input  CW  line number for oLineIrq, compared against the raw v counter
oVGA_HS  output  1  horizontal sync, polarity HS_POL
oVGA_VS  output  1  vertical sync, polarity VS_POL
oActive  output  1  visible-region flag
oVBlank  output  1  high while v is outside the active lines
oX  output  CW  active pixel column, 0..H_ACTIVE-1; 0 when not active
oY  output  CW  active line, 0..V_ACTIVE-1; 0 when not active
oLineStart  output  1  one-iclk pulse at h==0 of every line
oFrameStart  output  1  one-iclk pulse at h==0, v==0
oLineIrq  output  1  one-iclk pulse at h==0 when v==iLineCmp
oPixTick  output  1  registered pixel enable, one iclk per pixel

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise. Defaults give 800 x 525.
- Segment order within each axis: sync, back porch, active, front porch. Counter value 0 is the first sync pixel/line.
- Divider: div counts 0..CLK_DIV-1 and wraps. tick = (div==CLK_DIV-1). With CLK_DIV=1, tick is high every cycle.
- h increments on tick. When h==H_TOTAL-1 on tick, h goes to 0 and v advances; v wraps from V_TOTAL-1 to 0. Counters hold between ticks.
- Decode, all combinational from the current h/v:
  - hs_act = h<H_SYNC; vs_act = v<V_SYNC.
  - act = h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - X = h-(H_SYNC+H_BP); Y = v-(V_SYNC+V_BP); both forced to 0 when not act.
- Output register stage: every output is registered from the decode of the current h/v. Latency is exactly 1 iclk from counter state to pins, and outputs stay stable for CLK_DIV cycles per pixel.
- oVGA_HS = hs_act ? HS_POL : ~HS_POL; oVGA_VS likewise with VS_POL.
- Strobes are registered from (tick && h==0 ...):
  - oLineStart: tick && h==0.
  - oFrameStart: tick && h==0 && v==0.
  - oLineIrq: tick && h==0 && v==iLineCmp.
  - Each strobe lasts exactly one iclk regardless of CLK_DIV.
- oPixTick: registered tick.
- iLineCmp >= V_TOTAL: oLineIrq never fires. iLineCmp is sampled only on the h==0 tick; mid-line changes take effect next line.
- Reset (async assert, sync release):
  - Counters: div=0, h=0, v=0.
  - Outputs: HS/VS at inactive level (~POL), oActive=0, oVBlank=1, oX=oY=0, all strobes 0, oPixTick=0.
  - Reset mid-frame restarts the frame from h=0/v=0 with no partial-line artefacts beyond the asynchronous output clear.
- Elaboration-time checks:
  - Error if CW is too small for H_TOTAL-1 or V_TOTAL-1.
  - Error if CLK_DIV is outside 1..16.

Test Plan:
- Defaults, CLK_DIV=1, reset then free run: oLineStart period 800 cycles. oVGA_HS low for 96 cycles per line. oFrameStart period 420000 cycles. oVGA_VS low for exactly 2 lines (1600 cycles).
- Active window: first oActive=1 at h=144, v=35 with oX=0, oY=0. Last active pixel reports oX=639, oY=479. oActive is never high during HS low or oVBlank high.
- CLK_DIV=4: each oX value is held for 4 cycles, oPixTick fires every 4th cycle, and oLineStart stays 1 cycle wide with a 3200-cycle period.
- Small custom timing (H 2/2/4/2, V 1/1/3/1, HS_POL=1, VS_POL=1), checked pixel-by-pixel against a reference model: HS high for h 0..1, oActive for h 4..7 and v 2..4.
- iLineCmp=100: oLineIrq pulses once per frame, coincident with oLineStart at v=100. iLineCmp=600: no pulse over 2 frames.
- Assert irst at h=400, v=200 for 3 cycles: outputs clear immediately, then after release the first oFrameStart appears 1 cycle later and timing matches a fresh start.
